fb_pixel_packer: RTL and testbench

- Sits between the VGA/overlay pixel source and the DDR3 framebuffer write path.
- Consumes the framebuffer pixel stream (fb_vsync, fb_we, fb_data, fb_width, fb_height) and tracks the x/y raster position.
- Packs 4 pixels, each zero-padded to a 32-bit slot, into 128-bit DDR words with a byte mask and word address.
- Buffers packed words in a small FIFO with a valid/ready interface toward the DDR3 write scheduler.

---
 rtl/fb_pkg.sv | 24 ++
 rtl/fb_word_fifo.sv | 62 ++++++
 rtl/fb_pixel_packer.sv | 134 +++++++++++++
 tb/tb_fb_pixel_packer.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared types and helpers for the framebuffer pixel packer: DDR word layout
// and the word-address computation.
package fb_pkg;
  localparam int PIX_PER_WORD = 4;
  localparam int SLOT_BITS    = 32;
  localparam int WORD_BITS    = 128;
  localparam int MASK_BITS    = WORD_BITS / 8;
  localparam int ADDR_FIELD_W = 32;

  // Address field is wide enough for any geometry; the top trims it to ADDR_BITS.
  typedef struct packed {
    logic [ADDR_FIELD_W-1:0] addr;
    logic [WORD_BITS-1:0]    data;
    logic [MASK_BITS-1:0]    mask;
  } fb_word_t;

  localparam int FB_WORD_W = $bits(fb_word_t);

  function automatic logic [ADDR_FIELD_W-1:0] word_addr(input logic [15:0] y,
                                                          input logic [15:0] x,
                                                          input logic [15:0] pitch_words);
    return 32'(y) * 32'(pitch_words) + 32'(x >> 2);
  endfunction
endpackage

// File: rtl/fb_word_fifo.sv
// Packed-word FIFO with a registered head stage; words entering storage reach
// the head one cycle later. Pushes into a full FIFO without a pop are dropped.
module fb_word_fifo
  import fb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_push,
  input  logic [FB_WORD_W-1:0] i_word,
  input  logic                 i_ready,
  output logic                 o_valid,
  output logic [FB_WORD_W-1:0] o_word,
  output logic                 o_overflow
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fb_word_t      r_mem [DEPTH];
  logic [PW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_cnt;
  logic          r_vld;
  fb_word_t      r_out;
  logic          r_ovf;

  logic w_pop, w_full, w_wr, w_load;

  // Occupancy counts the head register too, so capacity is exactly DEPTH words.
  assign w_pop  = r_vld && i_ready;
  assign w_full = (r_cnt + CW'(r_vld)) == CW'(DEPTH);
  assign w_wr   = i_push && (!w_full || w_pop);
  assign w_load = (r_cnt != '0) && (!r_vld || w_pop);

  always_ff @(posedge clk)
    if (w_wr) r_mem[r_wp] <= fb_word_t'(i_word);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      r_vld <= 1'b0;
      r_out <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_wr) r_wp <= r_wp + PW'(1);
      if (w_load) begin
        r_rp  <= r_rp + PW'(1);
        r_out <= r_mem[r_rp];
      end
      r_cnt <= r_cnt + CW'(w_wr) - CW'(w_load);
      if (w_load)     r_vld <= 1'b1;
      else if (w_pop) r_vld <= 1'b0;
      if (i_push && w_full && !w_pop) r_ovf <= 1'b1;
    end
  end

  assign o_valid    = r_vld;
  assign o_word     = r_out;
  assign o_overflow = r_ovf;
endmodule

// File: rtl/fb_pixel_packer.sv
// Tracks raster position of the framebuffer pixel stream and packs four
// zero-extended pixels per 128-bit DDR word, queued toward the write scheduler.
module fb_pixel_packer
  import fb_pkg::*;
#(
  parameter int WIDTH      = 1024,
  parameter int HEIGHT     = 768,
  parameter int COLOR_BITS = 18,
  parameter int FIFO_DEPTH = 4,
  localparam int ADDR_BITS = $clog2(WIDTH * HEIGHT / 4)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [10:0]           fb_width,
  input  logic [9:0]            fb_height,
  input  logic                  fb_vsync,
  input  logic                  fb_we,
  input  logic [COLOR_BITS-1:0] fb_data,
  output logic                  wr_valid,
  input  logic                  wr_ready,
  output logic [ADDR_BITS-1:0]  wr_addr,
  output logic [127:0]          wr_data,
  output logic [15:0]           wr_mask,
  output logic                  overflow,
  output logic                  frame_done
);
  localparam logic [15:0] WIDTH_P  = 16'(WIDTH);
  localparam logic [15:0] HEIGHT_P = 16'(HEIGHT);
  localparam logic [15:0] PITCH    = 16'(WIDTH / PIX_PER_WORD);

  logic [15:0]          r_x, r_y, r_w, r_h;
  logic [WORD_BITS-1:0] r_acc_data;
  logic [MASK_BITS-1:0] r_acc_mask;
  logic [31:0]          r_acc_addr;
  logic                 r_frame_done;

  logic [15:0]          w_w_in, w_h_in, w_w, w_h, w_x, w_y, w_ylim;
  logic [1:0]           w_slot;
  logic                 w_write, w_eol, w_pix_emit, w_flush, w_push;
  logic [WORD_BITS-1:0] w_data_m;
  logic [MASK_BITS-1:0] w_mask_m;
  logic [31:0]          w_pix_addr;
  fb_word_t             w_push_word, w_head;
  logic [FB_WORD_W-1:0] w_head_bits;
  logic                 w_unused_addr;

  assign w_w_in = (fb_width == '0)  ? WIDTH_P  : 16'(fb_width);
  assign w_h_in = (fb_height == '0) ? HEIGHT_P : 16'(fb_height);

  // A vsync-cycle pixel already belongs to the new frame at (0,0).
  assign w_w  = fb_vsync ? w_w_in : r_w;
  assign w_h  = fb_vsync ? w_h_in : r_h;
  assign w_x  = fb_vsync ? 16'd0  : r_x;
  assign w_y  = fb_vsync ? 16'd0  : r_y;
  assign w_ylim = (w_h < HEIGHT_P) ? w_h : HEIGHT_P;

  assign w_slot     = w_x[1:0];
  assign w_write    = fb_we && (w_x < WIDTH_P) && (w_y < w_ylim);
  assign w_eol      = (w_x == w_w - 16'd1);
  assign w_pix_emit = w_write && ((w_slot == 2'd3) || w_eol);
  assign w_flush    = fb_vsync && (r_acc_mask != '0);
  assign w_push     = w_flush || w_pix_emit;
  assign w_pix_addr = word_addr(w_y, w_x, PITCH);

  always_comb begin
    w_data_m = fb_vsync ? '0 : r_acc_data;
    w_mask_m = fb_vsync ? '0 : r_acc_mask;
    w_data_m[w_slot*SLOT_BITS +: SLOT_BITS] = SLOT_BITS'(fb_data);
    w_mask_m[w_slot*4 +: 4] = 4'hF;
  end

  always_comb begin
    w_push_word = '{addr: w_pix_addr, data: w_data_m, mask: w_mask_m};
    if (w_flush) w_push_word = '{addr: r_acc_addr, data: r_acc_data, mask: r_acc_mask};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x          <= '0;
      r_y          <= '0;
      r_w          <= WIDTH_P;
      r_h          <= HEIGHT_P;
      r_acc_data   <= '0;
      r_acc_mask   <= '0;
      r_acc_addr   <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= fb_we && w_eol && (w_y == w_h - 16'd1);
      if (fb_vsync) begin
        r_w <= w_w_in;
        r_h <= w_h_in;
      end
      // y saturates at H so later pixels of the frame fall out as drops.
      if (fb_we) begin
        if (w_eol) begin
          r_x <= '0;
          r_y <= (w_y < w_h) ? w_y + 16'd1 : w_y;
        end else begin
          r_x <= w_x + 16'd1;
        end
      end else if (fb_vsync) begin
        r_x <= '0;
        r_y <= '0;
      end
      if (w_write && (!w_pix_emit || w_flush)) begin
        r_acc_data <= w_data_m;
        r_acc_mask <= w_mask_m;
        r_acc_addr <= w_pix_addr;
      end else if (w_pix_emit || fb_vsync) begin
        r_acc_data <= '0;
        r_acc_mask <= '0;
        r_acc_addr <= '0;
      end
    end
  end

  fb_word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_push),
    .i_word     (w_push_word),
    .i_ready    (wr_ready),
    .o_valid    (wr_valid),
    .o_word     (w_head_bits),
    .o_overflow (overflow)
  );

  assign w_head        = fb_word_t'(w_head_bits);
  assign wr_addr       = w_head.addr[ADDR_BITS-1:0];
  assign wr_data       = w_head.data;
  assign wr_mask       = w_head.mask;
  assign frame_done    = r_frame_done;
  assign w_unused_addr = ^w_head.addr[31:ADDR_BITS];
endmodule

// File: tb/tb_fb_pixel_packer.sv
// Scoreboard bench for fb_pixel_packer: default-geometry DUT plus a small
// geometry DUT for the full-frame end-of-frame case.
module tb_fb_pixel_packer;
  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [10:0]   fb_width = '0, fb_width2 = '0;
  logic [9:0]    fb_height = '0, fb_height2 = '0;
  logic          fb_vsync = 1'b0, fb_we = 1'b0, fb_vsync2 = 1'b0, fb_we2 = 1'b0;
  logic          wr_ready = 1'b1, wr_ready2 = 1'b1;
  logic [17:0]   fb_data = '0;
  logic          wr_valid, overflow, frame_done, wr_valid2, overflow2, frame_done2;
  logic [17:0]   wr_addr;
  logic [4:0]    wr_addr2;
  logic [127:0]  wr_data, wr_data2;
  logic [15:0]   wr_mask, wr_mask2;

  typedef struct packed {
    logic [31:0]  addr;
    logic [127:0] data;
    logic [15:0]  mask;
  } exp_t;

  exp_t q1[$], q2[$];
  exp_t e1, e2;
  int checks = 0, fails = 0, n1 = 0, n2 = 0, fd1 = 0, fd2 = 0, base;
  logic [31:0] last2 = '1;

  fb_pixel_packer #(.WIDTH(1024), .HEIGHT(768), .COLOR_BITS(18), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .fb_width(fb_width), .fb_height(fb_height),
    .fb_vsync(fb_vsync), .fb_we(fb_we), .fb_data(fb_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_mask(wr_mask), .overflow(overflow), .frame_done(frame_done)
  );

  fb_pixel_packer #(.WIDTH(32), .HEIGHT(4), .COLOR_BITS(18), .FIFO_DEPTH(4)) dut2 (
    .clk(clk), .rst(rst), .fb_width(fb_width2), .fb_height(fb_height2),
    .fb_vsync(fb_vsync2), .fb_we(fb_we2), .fb_data(fb_data),
    .wr_valid(wr_valid2), .wr_ready(wr_ready2), .wr_addr(wr_addr2),
    .wr_data(wr_data2), .wr_mask(wr_mask2), .overflow(overflow2), .frame_done(frame_done2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input int a, input logic [31:0] p0, p1, p2, p3, input logic [15:0] m);
    return '{addr: 32'(a), data: {p3, p2, p1, p0}, mask: m};
  endfunction

  task automatic cyc(); @(posedge clk); #1; endtask
  task automatic pix(input logic [17:0] d); fb_we = 1'b1; fb_data = d; cyc(); fb_we = 1'b0; endtask
  task automatic vs(); fb_vsync = 1'b1; cyc(); fb_vsync = 1'b0; endtask

  task automatic drain(input string nm, input int which);
    for (int i = 0; i < 200 && ((which == 1) ? q1.size() : q2.size()) != 0; i++) cyc();
    repeat (3) cyc();
    chk(nm, 128'((which == 1) ? q1.size() : q2.size()), 128'(0));
  endtask

  // Monitors: pop and compare on every accepted head word.
  always @(negedge clk) begin
    if (!rst && frame_done) fd1++;
    if (!rst && wr_valid && wr_ready) begin
      n1++;
      if (q1.size() == 0) begin
        checks++; fails++;
        $display("FAIL m1_extra_word act_addr=%0d exp=no_word", wr_addr);
      end else begin
        e1 = q1.pop_front();
        chk("m1_addr", 128'(wr_addr), 128'(e1.addr));
        chk("m1_data", wr_data, e1.data);
        chk("m1_mask", 128'(wr_mask), 128'(e1.mask));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && frame_done2) fd2++;
    if (!rst && wr_valid2 && wr_ready2) begin
      n2++;
      last2 = 32'(wr_addr2);
      if (q2.size() == 0) begin
        checks++; fails++;
        $display("FAIL m2_extra_word act_addr=%0d exp=no_word", wr_addr2);
      end else begin
        e2 = q2.pop_front();
        chk("m2_addr", 128'(wr_addr2), 128'(e2.addr));
        chk("m2_data", wr_data2, e2.data);
        chk("m2_mask", 128'(wr_mask2), 128'(e2.mask));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst = 1'b1;
    repeat (3) cyc();
    chk("reset_outs", 128'({wr_valid, wr_addr, wr_mask, overflow, frame_done}), 128'(0));
    chk("reset_data", wr_data, 128'(0));
    rst = 1'b0;
    cyc();

    // 1: 8x2 frame, four full words, one frame_done
    fb_width = 11'd8; fb_height = 10'd2;
    for (int k = 0; k < 4; k++)
      q1.push_back(mk((k / 2) * 256 + (k % 2), 4*k+1, 4*k+2, 4*k+3, 4*k+4, 16'hFFFF));
    vs();
    for (int i = 1; i <= 16; i++) pix(18'(i));
    drain("t1_drain", 1);
    chk("t1_frame_done", 128'(fd1), 128'(1));

    // 2: width 6, partial word at end of line
    fb_width = 11'd6;
    q1.push_back(mk(0, 1, 2, 3, 4, 16'hFFFF));
    q1.push_back(mk(1, 5, 6, 0, 0, 16'h00FF));
    vs();
    for (int i = 1; i <= 6; i++) pix(18'(i));
    drain("t2_drain", 1);

    // 3: vsync flushes a partial word; the vsync pixel starts the new frame
    fb_width = 11'd8;
    vs();
    q1.push_back(mk(0, 32'hA, 32'hB, 0, 0, 16'h00FF));
    q1.push_back(mk(0, 32'h3FFFF, 32'h21, 32'h22, 32'h23, 16'hFFFF));
    pix(18'hA); pix(18'hB);
    fb_vsync = 1'b1; pix(18'h3FFFF); fb_vsync = 1'b0;
    pix(18'h21); pix(18'h22); pix(18'h23);
    drain("t3_drain", 1);

    // 4: stalled consumer, six words into a 4-deep FIFO
    fb_width = 11'd0;
    wr_ready = 1'b0;
    chk("t4_ovf_before", 128'(overflow), 128'(0));
    vs();
    for (int k = 0; k < 4; k++)
      q1.push_back(mk(k, 32'h101+4*k, 32'h102+4*k, 32'h103+4*k, 32'h104+4*k, 16'hFFFF));
    for (int i = 0; i < 24; i++) pix(18'(32'h101 + i));
    repeat (3) cyc();
    chk("t4_valid_held", 128'(wr_valid), 128'(1));
    chk("t4_overflow", 128'(overflow), 128'(1));
    chk("t4_head_addr", 128'(wr_addr), 128'(0));
    chk("t4_head_data", wr_data, {32'h104, 32'h103, 32'h102, 32'h101});
    base = n1;
    wr_ready = 1'b1;
    drain("t4_drain", 1);
    chk("t4_drained_cnt", 128'(n1 - base), 128'(4));
    chk("t4_valid_after", 128'(wr_valid), 128'(0));

    // 5: reset mid-line with two words queued and three pixels accumulated
    wr_ready = 1'b0;
    vs();
    for (int i = 0; i < 11; i++) pix(18'(32'h200 + i));
    cyc();
    chk("t5_queued", 128'(wr_valid), 128'(1));
    rst = 1'b1;
    #1;
    chk("t5_rst_outs", 128'({wr_valid, wr_addr, wr_mask, overflow, frame_done}), 128'(0));
    chk("t5_rst_data", wr_data, 128'(0));
    cyc();
    rst = 1'b0;
    wr_ready = 1'b1;
    cyc();
    q1.push_back(mk(0, 32'h301, 32'h302, 32'h303, 32'h304, 16'hFFFF));
    for (int i = 1; i <= 4; i++) pix(18'(32'h300 + i));
    drain("t5_drain", 1);

    // 6: width/height 0 on a 32x4 instance, extra pixels dropped
    fd2 = 0;
    for (int k = 0; k < 32; k++)
      q2.push_back(mk(k, 4*k+1, 4*k+2, 4*k+3, 4*k+4, 16'hFFFF));
    fb_vsync2 = 1'b1; cyc(); fb_vsync2 = 1'b0;
    for (int i = 0; i < 136; i++) begin
      fb_we2 = 1'b1; fb_data = 18'(i + 1); cyc();
    end
    fb_we2 = 1'b0;
    drain("t6_drain", 2);
    chk("t6_word_cnt", 128'(n2), 128'(32));
    chk("t6_last_addr", 128'(last2), 128'(31));
    chk("t6_frame_done", 128'(fd2), 128'(1));
    chk("t6_overflow", 128'(overflow2), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
